// File: rtl/key_slice_scheduler.sv
// Key slice scheduler: latches a master key and streams NUM_SLICES subkeys per
// round over valid/ready, optionally rotating the key between rounds.
module key_slice_scheduler #(
  parameter int unsigned KEY_W      = 512,
  parameter int unsigned SLICE_W    = 64,
  parameter int unsigned NUM_SLICES = 8,
  parameter int unsigned ROT_STEP   = 13,
  parameter int unsigned RND_W      = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_key_valid,
  output logic                          o_key_ready,
  input  logic [KEY_W-1:0]              i_key_in,
  input  logic                          i_mode,
  input  logic [RND_W-1:0]              i_num_rounds,
  input  logic                          i_abort,
  output logic                          o_slice_valid,
  input  logic                          i_slice_ready,
  output logic [SLICE_W-1:0]            o_slice_data,
  output logic [$clog2(NUM_SLICES)-1:0] o_slice_idx,
  output logic [RND_W-1:0]              o_round_idx,
  output logic                          o_slice_last,
  output logic                          o_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_SLICES);

  if (KEY_W != SLICE_W * NUM_SLICES) begin : g_err_width
    $error("key_slice_scheduler: KEY_W must equal SLICE_W*NUM_SLICES");
  end
  if (ROT_STEP == 0 || ROT_STEP >= KEY_W) begin : g_err_rot
    $error("key_slice_scheduler: ROT_STEP must satisfy 0 < ROT_STEP < KEY_W");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [KEY_W-1:0]   r_key, w_key_nxt, w_key_rot;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [RND_W-1:0]   r_round, w_round_nxt;
  logic [RND_W-1:0]   r_rounds, w_rounds_nxt;
  logic               r_mode, w_mode_nxt;
  logic [SLICE_W-1:0] r_slice_data, w_slice_nxt;
  logic               r_slice_valid, w_valid_nxt;
  logic               r_slice_last, w_last_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_key_ready, w_key_ready_nxt;
  logic               w_last_slice, w_last_round;

  assign w_key_rot    = (r_key << ROT_STEP) | (r_key >> (KEY_W - ROT_STEP));
  assign w_last_slice = (r_idx == IDX_W'(NUM_SLICES - 1));
  assign w_last_round = (r_round == (r_rounds - RND_W'(1)));

  // Next-state and registered-output decode; outputs are computed from the
  // next-cycle state so every port is driven straight from a flop.
  always_comb begin
    w_state_nxt     = r_state;
    w_key_nxt       = r_key;
    w_idx_nxt       = r_idx;
    w_round_nxt     = r_round;
    w_rounds_nxt    = r_rounds;
    w_mode_nxt      = r_mode;
    w_slice_nxt     = '0;
    w_valid_nxt     = 1'b0;
    w_last_nxt      = 1'b0;
    w_busy_nxt      = 1'b0;
    w_key_ready_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!i_abort && i_key_valid) begin
          w_state_nxt  = S_EMIT;
          w_key_nxt    = i_key_in;
          w_mode_nxt   = i_mode;
          w_rounds_nxt = (i_num_rounds == '0) ? RND_W'(1) : i_num_rounds;
          w_idx_nxt    = '0;
          w_round_nxt  = '0;
        end
      end
      S_EMIT: begin
        if (i_abort || (i_slice_ready && w_last_slice && w_last_round)) begin
          // Job ends (abort or final beat): zeroise the held key.
          w_state_nxt = S_IDLE;
          w_key_nxt   = '0;
          w_idx_nxt   = '0;
          w_round_nxt = '0;
        end else if (i_slice_ready) begin
          if (w_last_slice) begin
            w_idx_nxt   = '0;
            w_round_nxt = r_round + RND_W'(1);
            if (r_mode) begin
              w_key_nxt = w_key_rot;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_key_nxt   = '0;
        w_idx_nxt   = '0;
        w_round_nxt = '0;
      end
    endcase

    for (int unsigned k = 0; k < NUM_SLICES; k++) begin
      if (w_idx_nxt == IDX_W'(k)) begin
        w_slice_nxt = w_key_nxt[KEY_W-1-k*SLICE_W -: SLICE_W];
      end
    end

    w_valid_nxt     = (w_state_nxt == S_EMIT);
    w_busy_nxt      = (w_state_nxt == S_EMIT);
    w_key_ready_nxt = (w_state_nxt == S_IDLE);
    w_last_nxt      = (w_state_nxt == S_EMIT) &&
                      (w_idx_nxt == IDX_W'(NUM_SLICES - 1)) &&
                      (w_round_nxt == (w_rounds_nxt - RND_W'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_key         <= '0;
      r_idx         <= '0;
      r_round       <= '0;
      r_rounds      <= RND_W'(1);
      r_mode        <= 1'b0;
      r_slice_data  <= '0;
      r_slice_valid <= 1'b0;
      r_slice_last  <= 1'b0;
      r_busy        <= 1'b0;
      r_key_ready   <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_key         <= w_key_nxt;
      r_idx         <= w_idx_nxt;
      r_round       <= w_round_nxt;
      r_rounds      <= w_rounds_nxt;
      r_mode        <= w_mode_nxt;
      r_slice_data  <= w_slice_nxt;
      r_slice_valid <= w_valid_nxt;
      r_slice_last  <= w_last_nxt;
      r_busy        <= w_busy_nxt;
      r_key_ready   <= w_key_ready_nxt;
    end
  end

  assign o_key_ready   = r_key_ready;
  assign o_slice_valid = r_slice_valid;
  assign o_slice_data  = r_slice_data;
  assign o_slice_idx   = r_idx;
  assign o_round_idx   = r_round;
  assign o_slice_last  = r_slice_last;
  assign o_busy        = r_busy;

endmodule
